// File: rtl/b11_scrambler_gen.sv
// Character scrambler: samples a strobed symbol, folds it with a rolling counter,
// reduces modulo KEY under an iteration guard, offsets, and emits the magnitude.
module b11_scrambler_gen #(
  parameter int unsigned W        = 6,
  parameter int unsigned KEY      = 26,
  parameter int unsigned CONT_MAX = 25,
  parameter int unsigned MAX_ITER = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         stbi,
  output logic [W-1:0] x_out,
  output logic         out_valid,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned CW = W + 3;
  localparam int unsigned IW = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);

  localparam logic signed [CW-1:0] KEY_S  = CW'(KEY);
  localparam logic signed [CW-1:0] OFF_00 = CW'(-21);
  localparam logic signed [CW-1:0] OFF_01 = CW'(-42);
  localparam logic signed [CW-1:0] OFF_10 = CW'(7);
  localparam logic signed [CW-1:0] OFF_11 = CW'(28);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_CLASSIFY, S_SEED, S_MIX, S_REDOWN, S_REUP, S_ADJUST, S_EMIT
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          cont_q, cont_d;
  logic [W-1:0]          r_in_q, r_in_d;
  logic signed [CW-1:0]  cont1_q, cont1_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic                  err_q, err_d;
  logic [W-1:0]          x_out_q, x_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_err_q, out_err_d;
  logic                  busy_q, busy_d;

  logic signed [CW-1:0]  r_ext, cont_ext;

  assign r_ext    = $signed({{(CW-W){1'b0}}, r_in_q});
  assign cont_ext = $signed({{(CW-W){1'b0}}, cont_q});

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    r_in_d      = r_in_q;
    cont1_d     = cont1_q;
    iter_d      = iter_q;
    err_d       = err_q;
    x_out_d     = x_out_q;
    out_valid_d = 1'b0;
    out_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cont_d  = '0;
        r_in_d  = x_in;
        x_out_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        r_in_d = x_in;
        if (!stbi) state_d = S_CLASSIFY;
      end
      S_CLASSIFY: begin
        if ((~|r_in_q) || (&r_in_q)) begin
          cont_d  = (32'(cont_q) < 32'(CONT_MAX)) ? cont_q + W'(1) : '0;
          cont1_d = r_ext;
          state_d = S_EMIT;
        end else if (32'(r_in_q) <= 32'(KEY)) begin
          state_d = S_SEED;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SEED: begin
        cont1_d = r_in_q[0] ? (cont_ext <<< 1) : cont_ext;
        iter_d  = '0;
        err_d   = 1'b0;
        state_d = S_MIX;
      end
      S_MIX: begin
        if (r_in_q[1]) begin
          cont1_d = r_ext + cont1_q;
          state_d = S_REDOWN;
        end else begin
          cont1_d = r_ext - cont1_q;
          state_d = S_REUP;
        end
      end
      S_REDOWN: begin
        if (iter_q == IW'(MAX_ITER)) begin
          err_d   = (cont1_q > KEY_S);
          state_d = S_ADJUST;
        end else if (cont1_q > KEY_S) begin
          cont1_d = cont1_q - KEY_S;
          iter_d  = iter_q + IW'(1);
        end else begin
          state_d = S_ADJUST;
        end
      end
      S_REUP: begin
        if (iter_q == IW'(MAX_ITER)) begin
          err_d   = cont1_q[CW-1];
          state_d = S_ADJUST;
        end else if (cont1_q[CW-1]) begin
          cont1_d = cont1_q + KEY_S;
          iter_d  = iter_q + IW'(1);
        end else begin
          state_d = S_ADJUST;
        end
      end
      S_ADJUST: begin
        case (r_in_q[3:2])
          2'b00:   cont1_d = cont1_q + OFF_00;
          2'b01:   cont1_d = cont1_q + OFF_01;
          2'b10:   cont1_d = cont1_q + OFF_10;
          default: cont1_d = cont1_q + OFF_11;
        endcase
        state_d = S_EMIT;
      end
      S_EMIT: begin
        // Low W bits of the negation depend only on the low W bits of cont1.
        x_out_d     = cont1_q[CW-1] ? (~cont1_q[W-1:0]) + W'(1) : cont1_q[W-1:0];
        out_valid_d = 1'b1;
        out_err_d   = err_q;
        state_d     = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cont_q      <= '0;
      r_in_q      <= '0;
      cont1_q     <= '0;
      iter_q      <= '0;
      err_q       <= 1'b0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      r_in_q      <= r_in_d;
      cont1_q     <= cont1_d;
      iter_q      <= iter_d;
      err_q       <= err_d;
      x_out_q     <= x_out_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      busy_q      <= busy_d;
    end
  end

  assign x_out     = x_out_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_b11_scrambler_gen.sv
// Bench for b11_scrambler_gen: two instances (default guard and MAX_ITER=1) driven
// in lockstep and compared against an arithmetic reference of the scrambling rules.
module tb_b11_scrambler_gen;

  localparam int W        = 6;
  localparam int KEY      = 26;
  localparam int CONT_MAX = 25;
  localparam int ALL1     = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] x_in;
  logic         stbi;
  logic [W-1:0] x_out_a, x_out_b;
  logic         out_valid_a, out_valid_b;
  logic         out_err_a, out_err_b;
  logic         busy_a, busy_b;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  int cont_m = 0;
  int err_ma = 0, err_mb = 0;
  int last_a = 0, last_b = 0;

  b11_scrambler_gen dut_a (
    .clock(clock), .reset(reset), .x_in(x_in), .stbi(stbi),
    .x_out(x_out_a), .out_valid(out_valid_a), .out_err(out_err_a), .busy(busy_a)
  );

  b11_scrambler_gen #(.MAX_ITER(1)) dut_b (
    .clock(clock), .reset(reset), .x_in(x_in), .stbi(stbi),
    .x_out(x_out_b), .out_valid(out_valid_b), .out_err(out_err_b), .busy(busy_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Result of one symbol; err is updated only for accepted symbols
  function automatic void ref_symbol(input int x, input int cont, input int max_iter,
                                     inout int err, output int xo, output bit valid);
    int v;
    int n;
    int offs[4] = '{-21, -42, 7, 28};
    valid = 1'b1;
    xo    = 0;
    if (x == 0 || x == ALL1) begin
      xo = x;
      return;
    end
    if (x > KEY) begin
      valid = 1'b0;
      return;
    end
    v = (x % 2 == 1) ? 2 * cont : cont;
    n = 0;
    if ((x / 2) % 2 == 1) begin
      v = x + v;
      while (v > KEY && n < max_iter) begin v -= KEY; n++; end
      err = (v > KEY) ? 1 : 0;
    end else begin
      v = x - v;
      while (v < 0 && n < max_iter) begin v += KEY; n++; end
      err = (v < 0) ? 1 : 0;
    end
    v  = v + offs[(x / 4) % 4];
    xo = ((v < 0) ? -v : v) % (1 << W);
  endfunction

  task automatic do_symbol(input int x, input string tag);
    int  ea, eb, xa, xb, oa, ob, pa, pb;
    bit  va, vb, done;
    ref_symbol(x, cont_m, 8, err_ma, ea, va);
    ref_symbol(x, cont_m, 1, err_mb, eb, vb);
    if (x == 0 || x == ALL1) cont_m = (cont_m < CONT_MAX) ? cont_m + 1 : 0;

    @(negedge clock);
    x_in = W'(x);
    stbi = 1'b0;
    @(negedge clock);
    stbi = 1'b1;
    pa = 0; pb = 0; xa = 0; xb = 0; oa = 0; ob = 0; done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid_a) begin pa++; xa = int'(x_out_a); oa = int'(out_err_a); end
      if (out_valid_b) begin pb++; xb = int'(x_out_b); ob = int'(out_err_b); end
      if (!busy_a && !busy_b) begin done = 1'b1; break; end
      @(negedge clock);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clock);
    if (out_valid_a) pa++;
    if (out_valid_b) pb++;
    check({tag, "_pulses_a"}, 32'(pa), 32'(va ? 1 : 0));
    check({tag, "_pulses_b"}, 32'(pb), 32'(vb ? 1 : 0));
    if (va) begin
      check({tag, "_xout_a"}, 32'(xa), 32'(ea));
      check({tag, "_err_a"},  32'(oa), 32'(err_ma));
      last_a = ea;
    end else begin
      check({tag, "_held_a"}, 32'(x_out_a), 32'(last_a));
    end
    if (vb) begin
      check({tag, "_xout_b"}, 32'(xb), 32'(eb));
      check({tag, "_err_b"},  32'(ob), 32'(err_mb));
      last_b = eb;
    end else begin
      check({tag, "_held_b"}, 32'(x_out_b), 32'(last_b));
    end
  endtask

  initial begin
    reset = 1'b1;
    stbi  = 1'b1;
    x_in  = '0;
    repeat (2) @(negedge clock);
    check("rst_xout",  32'(x_out_a),     32'd0);
    check("rst_valid", 32'(out_valid_a), 32'd0);
    check("rst_busy",  32'(busy_a),      32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", 32'(busy_a), 32'd0);

    // Zero symbols walk the counter through its wrap
    for (int i = 0; i < 26; i++) do_symbol(0, "zero");
    check("cont_wrapped", 32'(cont_m), 32'd0);

    do_symbol(3, "x3_c0");
    do_symbol(2, "x2_c0");
    do_symbol(40, "drop40");

    for (int i = 0; i < 5; i++) do_symbol(0, "zero_to5");
    do_symbol(4, "reup_x4");

    for (int i = 0; i < 20; i++) do_symbol(0, "zero_to25");
    do_symbol(3, "redown_x3");
    do_symbol(ALL1, "all_ones");

    // Strobe held: no progress regardless of x_in
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      x_in = W'($urandom_range(0, ALL1));
      check("hold_valid", 32'(out_valid_a | out_valid_b), 32'd0);
      check("hold_busy",  32'(busy_a | busy_b),           32'd0);
    end
    do_symbol(3, "after_hold");

    for (int i = 0; i < 40; i++) begin
      int r;
      r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ALL1)) : int'($urandom_range(0, KEY));
      do_symbol(r, "rand");
    end

    // Reset while reducing aborts with no pulse
    for (int i = 0; i < 3; i++) do_symbol(0, "pre_abort");
    @(negedge clock);
    x_in = W'(3);
    stbi = 1'b0;
    @(negedge clock);
    stbi = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_busy_before", 32'(busy_a), 32'd1);
    check("abort_no_pulse",    32'(out_valid_a), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_valid", 32'(out_valid_a | out_valid_b), 32'd0);
    check("abort_busy",  32'(busy_a | busy_b),           32'd0);
    check("abort_xout",  32'(x_out_a),                   32'd0);
    reset  = 1'b0;
    cont_m = 0; err_ma = 0; err_mb = 0; last_a = 0; last_b = 0;
    @(negedge clock);
    do_symbol(3, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
